// File: rtl/regfile_bank_if.sv
// Bus bundle for regfile_bank: one byte-enabled write port, two combinational read ports.
// master drives addresses/data/controls; slave (the bank) returns read data.
interface regfile_bank_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic                   clr;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [WIDTH/8-1:0]     wr_be;
    logic [WIDTH-1:0]       wr_data;
    logic [ADDR_W-1:0]      rd_addr1;
    logic [WIDTH-1:0]       rd_data1;
    logic [ADDR_W-1:0]      rd_addr2;
    logic [WIDTH-1:0]       rd_data2;

    modport master (
        output clr, wr_en, wr_addr, wr_be, wr_data, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_be, wr_data, rd_addr1, rd_addr2,
        output rd_data1, rd_data2
    );
endinterface

// File: rtl/regfile_bank.sv
// Register bank: DEPTH x WIDTH, byte-enabled write, two combinational reads, bulk clear.
// Optional same-cycle write forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module regfile_bank #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_bank_if.slave    rf
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_ok_s;
    logic             zero_hit1_s;
    logic             zero_hit2_s;
    logic [WIDTH-1:0] rd_data1_s;
    logic [WIDTH-1:0] rd_data2_s;

    // Byte-lane merge: enabled lanes take new data, others keep the stored word.
    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    // Write qualification and hardwired-zero read detection.
    always_comb begin
        wr_ok_s     = rf.wr_en && !((ZERO_REG != 0) && (rf.wr_addr == '0));
        zero_hit1_s = (ZERO_REG != 0) && (rf.rd_addr1 == '0);
        zero_hit2_s = (ZERO_REG != 0) && (rf.rd_addr2 == '0);
    end

    // Storage array: async reset, then clear beats write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (rf.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            mem_r[rf.wr_addr] <= merge_bytes(mem_r[rf.wr_addr], rf.wr_data, rf.wr_be);
        end else begin
            mem_r[rf.wr_addr] <= mem_r[rf.wr_addr];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read ports with forwarding of the in-flight write (and clear) in the same cycle.
    always_comb begin
        rd_data1_s = '0;
        rd_data2_s = '0;
        if (!rst_n || rf.clr || zero_hit1_s) begin
            rd_data1_s = '0;
        end else if (wr_ok_s && (rf.rd_addr1 == rf.wr_addr)) begin
            rd_data1_s = merge_bytes(mem_r[rf.rd_addr1], rf.wr_data, rf.wr_be);
        end else begin
            rd_data1_s = mem_r[rf.rd_addr1];
        end
        if (!rst_n || rf.clr || zero_hit2_s) begin
            rd_data2_s = '0;
        end else if (wr_ok_s && (rf.rd_addr2 == rf.wr_addr)) begin
            rd_data2_s = merge_bytes(mem_r[rf.rd_addr2], rf.wr_data, rf.wr_be);
        end else begin
            rd_data2_s = mem_r[rf.rd_addr2];
        end
    end
`else
    // Read ports reflecting stored contents only.
    always_comb begin
        rd_data1_s = '0;
        rd_data2_s = '0;
        if (!rst_n || zero_hit1_s) begin
            rd_data1_s = '0;
        end else begin
            rd_data1_s = mem_r[rf.rd_addr1];
        end
        if (!rst_n || zero_hit2_s) begin
            rd_data2_s = '0;
        end else begin
            rd_data2_s = mem_r[rf.rd_addr2];
        end
    end
`endif

    assign rf.rd_data1 = rd_data1_s;
    assign rf.rd_data2 = rd_data2_s;
endmodule

// File: tb/tb_regfile_bank.sv
// Bench for regfile_bank: two instances (ZERO_REG=1 and ZERO_REG=0) share stimulus and are
// checked every cycle against an array model, plus literal directed expectations.
module tb_regfile_bank;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [3:0]  wr_be = 4'h0;
    logic [31:0] wr_data = 32'h0;
    logic [4:0]  rd_addr1 = 5'd0;
    logic [4:0]  rd_addr2 = 5'd0;

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [2][32];
    logic [31:0] exp_bp;

    always #5 clk = ~clk;

    regfile_bank_if #(.WIDTH(32), .ADDR_W(5)) if_z ();
    regfile_bank_if #(.WIDTH(32), .ADDR_W(5)) if_n ();

    assign if_z.clr = clr;       assign if_n.clr = clr;
    assign if_z.wr_en = wr_en;   assign if_n.wr_en = wr_en;
    assign if_z.wr_addr = wr_addr; assign if_n.wr_addr = wr_addr;
    assign if_z.wr_be = wr_be;   assign if_n.wr_be = wr_be;
    assign if_z.wr_data = wr_data; assign if_n.wr_data = wr_data;
    assign if_z.rd_addr1 = rd_addr1; assign if_n.rd_addr1 = rd_addr1;
    assign if_z.rd_addr2 = rd_addr2; assign if_n.rd_addr2 = rd_addr2;

    regfile_bank #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)) u_z (
        .clk(clk), .rst_n(rst_n), .rf(if_z.slave)
    );
    regfile_bank #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0)) u_n (
        .clk(clk), .rst_n(rst_n), .rf(if_n.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // z=1 selects the ZERO_REG=1 model
    function automatic logic [31:0] exp_rd(input int z, input logic [4:0] a);
        logic [31:0] w;
        if (!rst_n) return 32'h0;
        if (z == 1 && a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (clr) return 32'h0;
        if (wr_en && a == wr_addr) begin
            w = mdl[z][a];
            for (int i = 0; i < 4; i++) if (wr_be[i]) w[8*i +: 8] = wr_data[8*i +: 8];
            return w;
        end
`endif
        return mdl[z][a];
    endfunction

    // Model state update at each rising edge
    always @(posedge clk) begin
        if (rst_n) begin
            for (int z = 0; z < 2; z++) begin
                if (clr) begin
                    for (int a = 0; a < 32; a++) mdl[z][a] = 32'h0;
                end else if (wr_en && !(z == 1 && wr_addr == 5'd0)) begin
                    for (int i = 0; i < 4; i++)
                        if (wr_be[i]) mdl[z][wr_addr][8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    always @(negedge rst_n) begin
        for (int z = 0; z < 2; z++)
            for (int a = 0; a < 32; a++) mdl[z][a] = 32'h0;
    end

    // Every-cycle comparison of both ports of both instances against the model
    always @(negedge clk) begin
        #2;
        chk("cmp_z_rd1", if_z.rd_data1, exp_rd(1, rd_addr1));
        chk("cmp_z_rd2", if_z.rd_data2, exp_rd(1, rd_addr2));
        chk("cmp_n_rd1", if_n.rd_data1, exp_rd(0, rd_addr1));
        chk("cmp_n_rd2", if_n.rd_data2, exp_rd(0, rd_addr2));
    end

    task automatic drv(input logic c, input logic we, input logic [4:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        clr = c; wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_addr1 = ra1; rd_addr2 = ra2;
    endtask

    initial begin
        for (int z = 0; z < 2; z++)
            for (int a = 0; a < 32; a++) mdl[z][a] = 32'h0;
        repeat (2) @(negedge clk);
        #1 chk("reset_rd1", if_z.rd_data1, 32'h0);
        rst_n = 1'b1;

        // byte-enable merge
        drv(1'b0, 1'b1, 5'd7, 4'hF, 32'h12345678, 5'd7, 5'd7);
        drv(1'b0, 1'b1, 5'd7, 4'b0010, 32'hAAAAAAAA, 5'd7, 5'd7);
        drv(1'b0, 1'b0, 5'd7, 4'h0, 32'h0, 5'd7, 5'd7);
        #1 chk("be_merge", if_z.rd_data1, 32'h1234AA78);

        // hardwired zero vs normal word 0
        drv(1'b0, 1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd0);
        drv(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);
        #1 chk("zero_reg_rd1", if_z.rd_data1, 32'h0);
        chk("zero_reg_rd2", if_z.rd_data2, 32'h0);
        chk("no_zero_reg", if_n.rd_data1, 32'hFFFFFFFF);

        // dual read and clear-beats-write
        drv(1'b0, 1'b1, 5'd3, 4'hF, 32'h11, 5'd3, 5'd3);
        drv(1'b0, 1'b1, 5'd9, 4'hF, 32'h22, 5'd9, 5'd9);
        drv(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd9, 5'd9);
        #1 chk("dual_rd1", if_z.rd_data1, 32'h22);
        chk("dual_rd2", if_z.rd_data2, 32'h22);
        drv(1'b1, 1'b1, 5'd4, 4'hF, 32'h33, 5'd3, 5'd4);
        drv(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd4);
        #1 chk("clr_a3", if_z.rd_data1, 32'h0);
        chk("clr_a4", if_z.rd_data2, 32'h0);
        drv(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd9, 5'd9);
        #1 chk("clr_a9", if_n.rd_data1, 32'h0);

        // same-cycle read of the word being written
        drv(1'b0, 1'b1, 5'd6, 4'hF, 32'hCAFEF00D, 5'd6, 5'd6);
`ifdef REGFILE_BYPASS_EN
        exp_bp = 32'hCAFEF00D;
`else
        exp_bp = 32'h0;
`endif
        #1 chk("bypass", if_z.rd_data1, exp_bp);
        drv(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd6, 5'd6);
        #1 chk("post_write", if_z.rd_data1, 32'hCAFEF00D);

        // async reset mid-cycle
        drv(1'b0, 1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 5'd5, 5'd5);
        drv(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5);
        #1 chk("pre_reset", if_z.rd_data1, 32'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", if_z.rd_data1, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 chk("after_release", if_z.rd_data1, 32'h0);
        @(negedge clk);
        #1 chk("after_edge", if_n.rd_data1, 32'h0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            clr = ($urandom_range(0, 39) == 0);
            wr_en = ($urandom_range(0, 9) < 7);
            wr_addr = 5'($urandom_range(0, 31));
            wr_be = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) begin
                #3 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        drv(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        #4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
